// File: rtl/pong_match_fsm.sv
// pong_match_fsm -- match-level controller for the pong collision/motion stage.
//
// Sequences IDLE -> SERVE -> PLAY -> POINT -> (SERVE | OVER) -> IDLE.
// In PLAY, the x velocity increases on every HITS_PER_STEP paddle hits.
// All outputs are registered, so every response appears one game tick after
// the event that causes it.
//
// Optional feature: define PONG_Y_SPEEDUP_EN to make each x velocity step
// also increase y_ball_vel, saturating at VEL_MAX.
//
// Ports:
//   game_clk   in   game tick clock, rising edge
//   reset      in   synchronous, active-high
//   start_btn  in   debounced start level; only rising edges act
//   wall_col   in   wall collision pulse (several ticks wide)
//   paddle_col in   paddle collision pulse (several ticks wide)
//   lossA      in   terminal score flag A, sampled when a point pause ends
//   lossB      in   terminal score flag B, sampled when a point pause ends
//   x_ball_vel out  [3:0] x velocity magnitude
//   y_ball_vel out  [3:0] y velocity magnitude
//   ball_hold  out  1 = hold the ball centred
//   score_clr  out  one-tick score clear strobe
//   state      out  [2:0] 0 IDLE, 1 SERVE, 2 PLAY, 3 POINT, 4 OVER
//   winner     out  [1:0] {lossB,lossA} captured on entry to OVER
//   rally_cnt  out  [7:0] paddle hits in the current rally, saturating
//
// Handshake note: there is no valid/ready interface. Every input is sampled
// on each tick, and the block acts on rising edges of the inputs.
module pong_match_fsm #(
  parameter int SERVE_TICKS   = 60,
  parameter int PAUSE_TICKS   = 90,
  parameter int VEL_INIT      = 2,
  parameter int VEL_MAX       = 8,
  parameter int HITS_PER_STEP = 4
) (
  input  logic       game_clk,
  input  logic       reset,
  input  logic       start_btn,
  input  logic       wall_col,
  input  logic       paddle_col,
  input  logic       lossA,
  input  logic       lossB,
  output logic [3:0] x_ball_vel,
  output logic [3:0] y_ball_vel,
  output logic       ball_hold,
  output logic       score_clr,
  output logic [2:0] state,
  output logic [1:0] winner,
  output logic [7:0] rally_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_POINT = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  // A tick count of 0 behaves as 1, so the counter is loaded with 0.
  localparam logic [7:0] SERVE_LOAD = (SERVE_TICKS < 1) ? 8'd0 : 8'(SERVE_TICKS - 1);
  localparam logic [7:0] PAUSE_LOAD = (PAUSE_TICKS < 1) ? 8'd0 : 8'(PAUSE_TICKS - 1);
  localparam logic [3:0] V_INIT     = 4'(VEL_INIT);
  localparam logic [3:0] V_MAX      = 4'(VEL_MAX);
  localparam logic [3:0] HIT_LAST   = 4'(HITS_PER_STEP - 1);

  state_t     state_q, state_d;
  logic [7:0] tick_q, tick_d;
  logic [3:0] hit_q, hit_d;
  logic [3:0] xv_q, xv_d, yv_q, yv_d;
  logic       hold_q, hold_d;
  logic       clr_q, clr_d;
  logic [1:0] win_q, win_d;
  logic [7:0] rally_q, rally_d;
  logic       start_prev, wall_prev, paddle_prev;
  logic       start_ev, wall_ev, paddle_ev;

  // The previous-sample registers reset to 1, so an input held high through
  // reset is not seen as a rising edge.
  assign start_ev  = start_btn  & ~start_prev;
  assign wall_ev   = wall_col   & ~wall_prev;
  assign paddle_ev = paddle_col & ~paddle_prev;

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    hit_d   = hit_q;
    xv_d    = xv_q;
    yv_d    = yv_q;
    hold_d  = hold_q;
    clr_d   = 1'b0;
    win_d   = win_q;
    rally_d = rally_q;
    case (state_q)
      ST_IDLE: begin
        xv_d   = 4'd0;
        yv_d   = 4'd0;
        hold_d = 1'b1;
        if (start_ev) begin
          state_d = ST_SERVE;
          tick_d  = SERVE_LOAD;
          clr_d   = 1'b1;
        end
      end
      ST_SERVE: begin
        xv_d   = 4'd0;
        yv_d   = 4'd0;
        hold_d = 1'b1;
        if (tick_q == 8'd0) begin
          state_d = ST_PLAY;
          xv_d    = V_INIT;
          yv_d    = V_INIT;
          rally_d = 8'd0;
          hit_d   = 4'd0;
          hold_d  = 1'b0;
        end else begin
          tick_d = tick_q - 8'd1;
        end
      end
      ST_PLAY: begin
        hold_d = 1'b0;
        // When wall and paddle edges occur in the same tick, the wall edge
        // takes priority and the paddle hit is not counted.
        if (wall_ev) begin
          state_d = ST_POINT;
          xv_d    = 4'd0;
          yv_d    = 4'd0;
          hold_d  = 1'b1;
          tick_d  = PAUSE_LOAD;
        end else if (paddle_ev) begin
          if (rally_q != 8'hFF) rally_d = rally_q + 8'd1;
          if (hit_q >= HIT_LAST) begin
            hit_d = 4'd0;
            if (xv_q < V_MAX) xv_d = xv_q + 4'd1;
`ifdef PONG_Y_SPEEDUP_EN
            if (yv_q < V_MAX) yv_d = yv_q + 4'd1;
`endif
          end else begin
            hit_d = hit_q + 4'd1;
          end
        end
      end
      ST_POINT: begin
        xv_d   = 4'd0;
        yv_d   = 4'd0;
        hold_d = 1'b1;
        if (tick_q == 8'd0) begin
          if (lossA | lossB) begin
            state_d = ST_OVER;
            win_d   = {lossB, lossA};
          end else begin
            state_d = ST_SERVE;
            tick_d  = SERVE_LOAD;
          end
        end else begin
          tick_d = tick_q - 8'd1;
        end
      end
      ST_OVER: begin
        xv_d   = 4'd0;
        yv_d   = 4'd0;
        hold_d = 1'b1;
        if (start_ev) begin
          state_d = ST_IDLE;
          win_d   = 2'd0;
          rally_d = 8'd0;
          clr_d   = 1'b1;
        end
      end
      default: begin
        // Unused encodings recover to IDLE with the reset-value outputs.
        state_d = ST_IDLE;
        tick_d  = 8'd0;
        hit_d   = 4'd0;
        xv_d    = 4'd0;
        yv_d    = 4'd0;
        hold_d  = 1'b1;
        win_d   = 2'd0;
        rally_d = 8'd0;
      end
    endcase
  end

  always_ff @(posedge game_clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      tick_q      <= 8'd0;
      hit_q       <= 4'd0;
      xv_q        <= 4'd0;
      yv_q        <= 4'd0;
      hold_q      <= 1'b1;
      clr_q       <= 1'b0;
      win_q       <= 2'd0;
      rally_q     <= 8'd0;
      start_prev  <= 1'b1;
      wall_prev   <= 1'b1;
      paddle_prev <= 1'b1;
    end else begin
      state_q     <= state_d;
      tick_q      <= tick_d;
      hit_q       <= hit_d;
      xv_q        <= xv_d;
      yv_q        <= yv_d;
      hold_q      <= hold_d;
      clr_q       <= clr_d;
      win_q       <= win_d;
      rally_q     <= rally_d;
      start_prev  <= start_btn;
      wall_prev   <= wall_col;
      paddle_prev <= paddle_col;
    end
  end

  assign x_ball_vel = xv_q;
  assign y_ball_vel = yv_q;
  assign ball_hold  = hold_q;
  assign score_clr  = clr_q;
  assign state      = state_q;
  assign winner     = win_q;
  assign rally_cnt  = rally_q;

endmodule

// File: doc/pong_match_fsm.md
Name: pong_match_fsm

Overview:
- Match-level controller directly upstream of the ball collision/motion stage.
- Consumes that stage's collision pulses (wall_col, paddle_col) and terminal-score flags (lossA, lossB).
- Drives the ball velocity magnitudes, a ball hold/re-centre request and a score-clear strobe.
- Sequences idle, serve delay, rally with speed-up on paddle hits, point pause and game over.

Parameters:
SERVE_TICKS, 60, game ticks the ball is held centred before each serve (1..255; 0 behaves as 1)
PAUSE_TICKS, 90, game ticks of pause after a point (1..255; 0 behaves as 1)
VEL_INIT, 2, initial x and y velocity magnitude at each serve (1..15)
VEL_MAX, 8, saturation value for velocity (VEL_INIT..15)
HITS_PER_STEP, 4, paddle hits per +1 x-velocity step (1..15)

Ports:
game_clk  in  1  game tick clock, all logic on rising edge
reset  in  1  synchronous, active-high
start_btn  in  1  level from debounced start button; only rising edges act
wall_col  in  1  from collision stage; high for several ticks per event
paddle_col  in  1  from collision stage; high for several ticks per event
lossA  in  1  collision stage terminal score flag A
lossB  in  1  collision stage terminal score flag B
x_ball_vel  out  4  x velocity magnitude to collision stage
y_ball_vel  out  4  y velocity magnitude to collision stage
ball_hold  out  1  1 = collision stage must hold ball at default position (drives its active-low reset via inversion)
score_clr  out  1  one-tick pulse clearing collision-stage scores
state  out  3  0 IDLE, 1 SERVE, 2 PLAY, 3 POINT, 4 OVER
winner  out  2  {lossB,lossA} captured on entry to OVER; 0 otherwise
rally_cnt  out  8  paddle hits in current rally, saturates at 255

Behaviour:
- Decided: one clock, game_clk. Reset is synchronous, active-high, port named reset.
- Reset values: state=IDLE, x/y_ball_vel=0, ball_hold=1, score_clr=0, winner=0, rally_cnt=0, internal tick counter=0, hit counter=0.
- Edge-detect previous-sample registers load 1 at reset, so inputs held high through reset produce no edge.
- Reset asserted in any state forces the reset values on the next edge and overrides all other events.
- Edge detection: ev_x = x & ~x_prev, registered each tick. Each multi-tick collision pulse counts exactly once. All events act in the tick the edge is detected; outputs are registered (1-tick latency).
- IDLE:
  - vel=0, ball_hold=1.
  - start edge -> SERVE, load tick counter SERVE_TICKS-1, score_clr=1 for that single tick.
- SERVE:
  - vel=0, ball_hold=1. Counter decrements each tick.
  - At 0 -> PLAY: x_vel=y_vel=VEL_INIT, rally_cnt=0, hit counter=0, ball_hold=0.
- PLAY:
  - ball_hold=0.
  - paddle edge: rally_cnt+1 (saturate 255); hit counter+1. When hit counter reaches HITS_PER_STEP, it clears to 0 and x_vel+1 (saturate VEL_MAX).
  - wall edge -> POINT: vel=0, ball_hold=1, counter=PAUSE_TICKS-1. rally_cnt holds its value for display.
  - Wall and paddle edges in the same tick: wall wins; no hit counted.
  - start edges are ignored.
- POINT:
  - vel=0, ball_hold=1. Counter decrements.
  - At 0: if lossA|lossB -> OVER, winner={lossB,lossA}. Otherwise -> SERVE, counter=SERVE_TICKS-1.
  - lossA/lossB are sampled only at this transition.
- OVER:
  - vel=0, ball_hold=1, winner held.
  - start edge -> IDLE: winner=0, rally_cnt=0, score_clr=1 for one tick.
- Arithmetic: all increments saturate; no wrap-around. Velocity never exceeds VEL_MAX and is never 0 in PLAY.
- Unused state encodings 5..7 -> IDLE next tick with reset-value outputs.

Optional Feature:
PONG_Y_SPEEDUP_EN
- Defined: each x velocity step also increments y_ball_vel by 1, saturating at VEL_MAX, in the same tick.
- Undefined: y_ball_vel stays at VEL_INIT throughout PLAY.

Test Plan:
- Reset held 3 ticks with start_btn=1, then released -> state=0, ball_hold=1, vel=0. No transition until start_btn falls and rises again.
- start edge with SERVE_TICKS=60 -> score_clr high exactly 1 tick, then state=1 for 60 ticks, then state=2 with x_vel=y_vel=2 and ball_hold=0.
- In PLAY, 8 paddle_col pulses each 8 ticks wide:
  - rally_cnt=8 and x_vel=4.
  - y_vel=2 without PONG_Y_SPEEDUP_EN; y_vel=4 with it.
  - 40 pulses -> x_vel saturates at 8.
- wall_col and paddle_col rising in the same tick -> state=3, rally_cnt unchanged, vel=0. After 90 ticks state=1 (lossA=lossB=0).
- lossA=1 at POINT expiry -> state=4, winner=2'b01. start edge -> state=0, winner=0, score_clr 1-tick pulse.
- Reset asserted mid-PLAY with x_vel=6 -> next tick state=0, vel=0, rally_cnt=0, ball_hold=1.
